// File: rtl/fsm_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fsm_pkg
// Description : Shared state encoding and saturation helper for run_gate_fsm.
// Revision    : 1.0 - initial release
// ============================================================================
package fsm_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        STOP  = 2'd2
    } state_t;

    localparam int unsigned MAX_CNT_W = 64;

    // All-ones value of the given width; callers truncate to their counter width.
    function automatic logic [MAX_CNT_W-1:0] all_ones(input int unsigned width);
        if (width >= MAX_CNT_W)
            return '1;
        return (64'd1 << width) - 64'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/run_gate_fsm_ch.sv
`default_nettype none
// ============================================================================
// Module      : run_gate_ch
// Description : One channel: input debounce, IDLE/START/STOP FSM, run counter.
// Revision    : 1.0 - initial release
// ============================================================================
module run_gate_ch
    import fsm_pkg::*;
#(
    parameter int HOLD  = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             a,
    output logic             z,
    output logic             start_pulse,
    output logic             stop_pulse,
    output logic             run_len_valid,
    output logic [CNT_W-1:0] run_len
);

    localparam int               SC_W      = (HOLD > 1) ? $clog2(HOLD) : 1;
    localparam logic [SC_W-1:0]  C_SC_LAST = SC_W'(HOLD - 1);
    localparam logic [CNT_W-1:0] C_RC_MAX  = CNT_W'(all_ones(CNT_W));
    localparam logic [CNT_W-1:0] C_RC_ONE  = CNT_W'(1);

    logic             af_q, af_d;
    logic [SC_W-1:0]  sc_q, sc_d;
    state_t           state_q, state_d;
    logic [CNT_W-1:0] rc_q, rc_d;
    logic             z_q, z_d;
    logic             start_q, start_d;
    logic             stop_q, stop_d;
    logic [CNT_W-1:0] run_len_q, run_len_d;

    always_comb begin
        af_d      = af_q;
        sc_d      = sc_q;
        state_d   = state_q;
        rc_d      = rc_q;
        z_d       = z_q;
        start_d   = 1'b0;
        stop_d    = 1'b0;
        run_len_d = run_len_q;

        if (en) begin
            if (a == af_q) begin
                sc_d = '0;
            end else if (sc_q == C_SC_LAST) begin
                af_d = a;
                sc_d = '0;
            end else begin
                sc_d = sc_q + 1'b1;
            end

            // FSM reacts to the filtered level as it stood before this edge.
            case (state_q)
                IDLE: begin
                    if (af_q) begin
                        state_d = START;
                        rc_d    = C_RC_ONE;
                        start_d = 1'b1;
                    end
                end
                START: begin
                    if (!af_q) begin
                        state_d   = STOP;
                        stop_d    = 1'b1;
                        run_len_d = rc_q;
                    end else if (rc_q != C_RC_MAX) begin
                        rc_d = rc_q + 1'b1;
                    end
                end
                STOP: begin
                    if (!af_q)
                        state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase

            z_d = (state_d == START);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            af_q      <= 1'b0;
            sc_q      <= '0;
            state_q   <= IDLE;
            rc_q      <= '0;
            z_q       <= 1'b0;
            start_q   <= 1'b0;
            stop_q    <= 1'b0;
            run_len_q <= '0;
        end else begin
            af_q      <= af_d;
            sc_q      <= sc_d;
            state_q   <= state_d;
            rc_q      <= rc_d;
            z_q       <= z_d;
            start_q   <= start_d;
            stop_q    <= stop_d;
            run_len_q <= run_len_d;
        end
    end

    assign z             = z_q;
    assign start_pulse   = start_q;
    assign stop_pulse    = stop_q;
    assign run_len_valid = stop_q;
    assign run_len       = run_len_q;

endmodule
`default_nettype wire

// File: rtl/run_gate_fsm.sv
`default_nettype none
// ============================================================================
// Module      : run_gate_fsm
// Description : Multi-channel debounced start/stop detector with run length.
// Revision    : 1.0 - initial release
// ============================================================================
module run_gate_fsm
    import fsm_pkg::*;
#(
    parameter int CH    = 2,
    parameter int HOLD  = 4,
    parameter int CNT_W = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                en,
    input  logic [CH-1:0]       a,
    output logic [CH-1:0]       z,
    output logic [CH-1:0]       start_pulse,
    output logic [CH-1:0]       stop_pulse,
    output logic [CH*CNT_W-1:0] run_len,
    output logic [CH-1:0]       run_len_valid
);

    generate
        for (genvar i = 0; i < CH; i++) begin : g_ch
            run_gate_ch #(
                .HOLD  (HOLD),
                .CNT_W (CNT_W)
            ) u_ch (
                .clk           (clk),
                .reset         (reset),
                .en            (en),
                .a             (a[i]),
                .z             (z[i]),
                .start_pulse   (start_pulse[i]),
                .stop_pulse    (stop_pulse[i]),
                .run_len_valid (run_len_valid[i]),
                .run_len       (run_len[i*CNT_W +: CNT_W])
            );
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_run_gate_fsm.sv
`default_nettype none
// ============================================================================
// Module      : tb_run_gate_fsm
// Description : Scoreboard bench for run_gate_fsm (HOLD=4 and HOLD=1 instances).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_run_gate_fsm;

    localparam int HOLD0 = 4;
    localparam int HOLD1 = 1;
    localparam int CW    = 4;
    localparam int NCH   = 4;
    localparam int C_MAX = 15;

    logic       clk = 1'b0;
    logic       reset;
    logic       en;
    logic [3:0] a_all;

    always #5 clk = ~clk;

    logic [1:0] z0, z1, sp0, sp1, st0, st1, v0, v1;
    logic [7:0] rl0, rl1;

    run_gate_fsm #(.CH(2), .HOLD(HOLD0), .CNT_W(CW)) u_dut0 (
        .clk(clk), .reset(reset), .en(en), .a(a_all[1:0]),
        .z(z0), .start_pulse(sp0), .stop_pulse(st0),
        .run_len(rl0), .run_len_valid(v0)
    );

    run_gate_fsm #(.CH(2), .HOLD(HOLD1), .CNT_W(CW)) u_dut1 (
        .clk(clk), .reset(reset), .en(en), .a(a_all[3:2]),
        .z(z1), .start_pulse(sp1), .stop_pulse(st1),
        .run_len(rl1), .run_len_valid(v1)
    );

    logic [3:0]  z_all, sp_all, st_all, v_all;
    logic [15:0] rl_all;
    assign z_all  = {z1, z0};
    assign sp_all = {sp1, sp0};
    assign st_all = {st1, st0};
    assign v_all  = {v1, v0};
    assign rl_all = {rl1, rl0};

    int checks = 0;
    int errors = 0;
    bit mon_on = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: filtered level, "running" and "armed" flags, run length.
    bit m_af[NCH];
    int m_sc[NCH];
    bit m_run[NCH];
    bit m_armed[NCH];
    int m_len[NCH];
    int m_last[NCH];
    int q_ev[NCH][$];   // -1 = start event, >=0 = stop event carrying its length

    function automatic int hold_of(input int k);
        return (k < 2) ? HOLD0 : HOLD1;
    endfunction

    always @(posedge clk) begin
        for (int k = 0; k < NCH; k++) begin
            if (reset) begin
                m_af[k] = 1'b0; m_sc[k] = 0; m_run[k] = 1'b0; m_armed[k] = 1'b1;
                m_len[k] = 0; m_last[k] = 0;
                q_ev[k].delete();
            end else if (en) begin
                if (!m_run[k] && m_armed[k] && m_af[k]) begin
                    m_run[k] = 1'b1; m_len[k] = 1;
                    q_ev[k].push_back(-1);
                end else if (m_run[k] && !m_af[k]) begin
                    m_run[k] = 1'b0; m_armed[k] = 1'b0; m_last[k] = m_len[k];
                    q_ev[k].push_back(m_len[k]);
                end else if (m_run[k]) begin
                    if (m_len[k] < C_MAX) m_len[k]++;
                end else if (!m_armed[k] && !m_af[k]) begin
                    m_armed[k] = 1'b1;
                end
                if (a_all[k] == m_af[k]) m_sc[k] = 0;
                else if (m_sc[k] == hold_of(k) - 1) begin m_af[k] = a_all[k]; m_sc[k] = 0; end
                else m_sc[k]++;
            end
        end
    end

    // Monitor: compares DUT outputs against the model away from the active edge.
    always @(negedge clk) begin
        int ev;
        if (mon_on) begin
            for (int k = 0; k < NCH; k++) begin
                chk($sformatf("z[%0d]", k), z_all[k], m_run[k]);
                chk($sformatf("run_len[%0d]", k), rl_all[k*CW +: CW], m_last[k]);
                if (q_ev[k].size() > 0) begin
                    ev = q_ev[k].pop_front();
                    if (ev < 0)
                        chk($sformatf("start_evt[%0d]", k), {sp_all[k], st_all[k], v_all[k]}, 3'b100);
                    else
                        chk($sformatf("stop_evt[%0d]", k), {sp_all[k], st_all[k], v_all[k]}, 3'b011);
                end else begin
                    chk($sformatf("no_pulse[%0d]", k), {sp_all[k], st_all[k], v_all[k]}, 3'b000);
                end
            end
        end
    end

    task automatic step(input logic [3:0] av, input logic e, input logic r, input int n);
        repeat (n) begin
            @(negedge clk);
            a_all = av; en = e; reset = r;
        end
    endtask

    task automatic settle_check();
        @(posedge clk);
        #1;
    endtask

    logic [3:0] rnd_a;

    initial begin
        reset = 1'b1; en = 1'b1; a_all = 4'b1111;
        @(posedge clk);
        #1 mon_on = 1'b1;

        // Reset held with inputs high, then release.
        step(4'b1111, 1'b1, 1'b1, 2);
        step(4'b1111, 1'b1, 1'b0, 10);
        step(4'b0000, 1'b1, 1'b0, 8);
        settle_check();
        chk("release_run_len0", rl0[3:0], 10);
        chk("release_run_len1", rl0[7:4], 10);

        // Normal 10-cycle run on channel 0 only.
        step(4'b0101, 1'b1, 1'b0, 10);
        step(4'b0000, 1'b1, 1'b0, 10);
        settle_check();
        chk("normal_run_len0", rl0[3:0], 10);
        chk("normal_ch1_untouched", rl0[7:4], 10);

        // Glitch shorter than HOLD, then exactly HOLD.
        step(4'b1010, 1'b1, 1'b0, 3);
        step(4'b0000, 1'b1, 1'b0, 8);
        settle_check();
        chk("glitch_run_len1", rl0[7:4], 10);
        step(4'b1010, 1'b1, 1'b0, 4);
        step(4'b0000, 1'b1, 1'b0, 10);
        settle_check();
        chk("hold_run_len1", rl0[7:4], 4);

        // Saturation at 2^CW-1.
        step(4'b0101, 1'b1, 1'b0, 20);
        step(4'b0000, 1'b1, 1'b0, 10);
        settle_check();
        chk("sat_run_len0", rl0[3:0], C_MAX);

        // Enable freeze mid-run.
        step(4'b0101, 1'b1, 1'b0, 5);
        step(4'b0101, 1'b0, 1'b0, 5);
        step(4'b0101, 1'b1, 1'b0, 5);
        step(4'b0000, 1'b1, 1'b0, 10);
        settle_check();
        chk("freeze_run_len0", rl0[3:0], 10);

        // Reset during START.
        step(4'b0101, 1'b1, 1'b0, 8);
        step(4'b0101, 1'b1, 1'b1, 1);
        settle_check();
        chk("midreset_z0", z0[0], 1'b0);
        chk("midreset_stop0", st0[0], 1'b0);
        chk("midreset_run_len0", rl0[3:0], 0);
        step(4'b0000, 1'b1, 1'b0, 10);

        // One-cycle dip: HOLD=1 channel re-rises during STOP.
        step(4'b0101, 1'b1, 1'b0, 4);
        step(4'b0000, 1'b1, 1'b0, 1);
        step(4'b0101, 1'b1, 1'b0, 4);
        step(4'b0000, 1'b1, 1'b0, 6);

        // Randomized bursty traffic with occasional enable drops and resets.
        rnd_a = 4'b0000;
        for (int i = 0; i < 800; i++) begin
            for (int b = 0; b < 4; b++)
                if ($urandom_range(0, 5) == 0) rnd_a[b] = ~rnd_a[b];
            step(rnd_a, ($urandom_range(0, 9) != 0), ($urandom_range(0, 299) == 0), 1);
        end
        step(4'b0000, 1'b1, 1'b0, 12);
        settle_check();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
